spike_ram_reader: RTL and testbench
===================================

// Module: spike_ram_reader
// PURPOSE
//  Read-side engine for the spike dual-port BRAM (1-cycle registered read on port B).
//  On a start command, reads LEN consecutive words from BASE, wrapping at DEPTH.
//  Emits them as a valid/ready stream with a last flag to the downstream neuron core.
//  Absorbs the RAM read latency with a 2-entry skid FIFO, so backpressure never drops or duplicates data.
// PARAMETERS
//  ADDR_W  10    RAM address width; DEPTH = 2**ADDR_W words
//  DATA_W  8     RAM word / stream data width
// PORTS
//  clk        in   1         single clock; drives this block and RAM port B
//  rst_n      in   1         asynchronous active-low reset
//  start      in   1         command strobe; accepted only when busy==0
//  base_addr  in   ADDR_W    first word address, sampled with start
//  length     in   ADDR_W+1  word count 0..DEPTH, sampled with start
//  abort      in   1         synchronous cancel of the current command
//  busy       out  1         command in progress (RUN or DRAIN)
//  done       out  1         1-cycle pulse when the command completes or is aborted
//  ram_addr   out  ADDR_W    to RAM addrb
//  ram_dout   in   DATA_W    from RAM doutb, valid 1 edge after ram_addr is sampled
//  m_valid    out  1         stream word valid
//  m_ready    in   1         downstream accept
//  m_data     out  DATA_W    stream word
//  m_last     out  1         marks the final word of the command
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_addr=0.
//    FIFO, in-flight flag and counters are cleared. Reset mid-command discards everything; no done pulse.
//  - FSM states:
//    - IDLE: start=1 & length!=0 -> RUN. Load addr=base_addr, issue_cnt=length, out_cnt=length.
//    - IDLE: start=1 & length==0 -> done=1 next cycle; stay IDLE; no beats.
//    - RUN: when issue_cnt reaches 0 after the last read issue -> DRAIN.
//    - DRAIN: the beat with out_cnt==1 is accepted (m_valid&m_ready) -> IDLE, done=1 that next cycle.
//    - abort=1 in RUN or DRAIN: -> IDLE next cycle; FIFO and in-flight flag flushed; m_valid=0; done=1 once.
//      abort in IDLE: ignored.
//  - start while busy is ignored; base_addr and length are not resampled.
//  - Read issue: in RUN, issue when issue_cnt!=0 and (fifo_cnt + inflight - pop) < 2,
//    where pop = m_valid & m_ready.
//    - On issue: addr<=addr+1 (mod DEPTH, natural ADDR_W wrap 1023->0), issue_cnt--, inflight<=1.
//    - ram_addr = addr register (held when not issuing).
//  - Capture: the cycle after an issue, ram_dout is pushed into the FIFO. The push never overflows (credit rule).
//  - Stream: m_valid = FIFO non-empty. m_data = FIFO head. m_last = (out_cnt==1) & m_valid.
//    - Data and last stay stable while m_valid & !m_ready.
//    - pop decrements out_cnt.
//  - Latency: start sampled at edge N -> ram_addr=base during cycle N+1 -> m_valid=1, m_data=mem[base] after edge N+2.
//  - Throughput: 1 word/cycle sustained with m_ready held high.
//  - Simultaneous FIFO push and pop: both occur; fifo_cnt unchanged.
//  - length==DEPTH: reads every word once, ending at base-1 (wrapped).
//  - done and m_last never assert in the same cycle. done follows the last pop by 1 cycle.
// STRUCTURE
//  - Shared package spike_mem_pkg:
//    - ADDR_W/DATA_W defaults.
//    - FSM state enum {IDLE, RUN, DRAIN}, 2-bit encoding.
//  - One sub-module: spike_skid_fifo2. 2-entry, DATA_W-wide, push/pop/cnt, async active-low reset.
//  - The RAM is external; the bench instantiates the existing spike BRAM with clka=clkb=clk.
// TESTING (RAM preloaded mem[i]=i[7:0])
//  1. base=5, len=4, m_ready=1 -> beats 05,06,07,08 on consecutive cycles. last on 08; done 1 cycle after.
//  2. base=1022, len=4 -> beats FE,FF,00,01. ram_addr sequence 1022,1023,0,1.
//  3. base=0, len=8, m_ready toggles 1/0 each cycle -> 00..07 in order.
//     No loss or duplication; m_data held while stalled; fifo_cnt never exceeds 2.
//  4. len=0 -> done pulses next cycle; m_valid stays 0. start while busy -> ignored; stream unchanged.
//  5. abort after 2 of 10 beats (m_ready=0) -> next cycle: m_valid=0, busy=0, done=1.
//     Follow-up start base=0 len=1 -> single beat 00 with last.
//  6. rst_n pulsed low mid-stream (async, between edges) -> all outputs 0 immediately; no done.
//     Subsequent command behaves as in test 1.

Source files
------------

// File: rtl/spike_mem_pkg.sv
// Shared constants and FSM encoding for the spike memory read path.
package spike_mem_pkg;

  localparam int SPIKE_ADDR_W = 10;
  localparam int SPIKE_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/spike_ram_reader_if.sv
// Valid/ready stream carrying spike words and a last flag to the neuron core.
interface spike_ram_reader_if
  import spike_mem_pkg::*;
#(
  parameter int DATA_W = SPIKE_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/spike_skid_fifo2.sv
// Two-entry skid FIFO that absorbs the one-cycle RAM read latency under backpressure.
module spike_skid_fifo2
  import spike_mem_pkg::*;
#(
  parameter int DATA_W = SPIKE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_dout,
  output logic [1:0]        o_cnt
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_cnt;
  logic              w_read;

  assign w_read  = i_pop & (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_dout  = r_mem[r_rdPtr];
  assign o_cnt   = r_cnt;

  // Flush drops any stored words; the upstream credit rule guarantees a push never finds the FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_din;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_read) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_read};
    end
  end

endmodule

// File: rtl/spike_ram_reader.sv
// Reads a wrapped block of words from the spike BRAM and streams them out with a last marker.
module spike_ram_reader
  import spike_mem_pkg::*;
#(
  parameter int ADDR_W = SPIKE_ADDR_W,
  parameter int DATA_W = SPIKE_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_base_addr,
  input  logic [ADDR_W:0]    i_length,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic [ADDR_W-1:0]  o_ram_addr,
  input  logic [DATA_W-1:0]  i_ram_dout,
  spike_ram_reader_if.master m_stream
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issueCnt;
  logic [ADDR_W:0]   r_outCnt;
  logic              r_inflight;
  logic              r_done;
  logic              w_doneNext;
  logic              w_load;
  logic              w_flush;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occupancy;
  logic              w_fifoValid;
  logic [DATA_W-1:0] w_fifoData;
  logic [1:0]        w_fifoCnt;

  // Buffered plus in-flight words, minus the one leaving now, must leave room for another read.
  assign w_pop       = w_fifoValid & m_stream.ready;
  assign w_occupancy = {1'b0, w_fifoCnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == RUN) & (r_issueCnt != '0) & (w_occupancy < 3'd2);

  always_comb begin
    w_nextState = r_state;
    w_doneNext  = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_length != '0) begin
            w_nextState = RUN;
            w_load      = 1'b1;
          end else begin
            w_doneNext = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
          w_flush     = 1'b1;
        end else if (w_issue && (r_issueCnt == CNT_ONE)) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (i_abort) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
          w_flush     = 1'b1;
        end else if (w_pop && (r_outCnt == CNT_ONE)) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_issueCnt <= '0;
      r_outCnt   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_done     <= w_doneNext;
      r_inflight <= w_issue & ~w_flush;
      if (w_load) begin
        r_addr     <= i_base_addr;
        r_issueCnt <= i_length;
        r_outCnt   <= i_length;
      end else begin
        if (w_issue) begin
          r_addr     <= r_addr + ADDR_W'(1);
          r_issueCnt <= r_issueCnt - CNT_ONE;
        end
        if (w_pop) begin
          r_outCnt <= r_outCnt - CNT_ONE;
        end
      end
    end
  end

  spike_skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (r_inflight),
    .i_din   (i_ram_dout),
    .i_pop   (w_pop),
    .o_valid (w_fifoValid),
    .o_dout  (w_fifoData),
    .o_cnt   (w_fifoCnt)
  );

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_ram_addr    = r_addr;
  assign m_stream.valid = w_fifoValid;
  assign m_stream.data  = w_fifoData;
  assign m_stream.last  = (r_outCnt == CNT_ONE) & w_fifoValid;

endmodule

// File: tb/tb_spike_ram_reader.sv
// Directed bench for spike_ram_reader against a behavioural 1-cycle BRAM preloaded with mem[i]=i.
module tb_spike_ram_reader;
  import spike_mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDout;
  logic [DATA_W-1:0] mem [1024];

  logic [DATA_W-1:0] expQ [$];
  logic [ADDR_W-1:0] addrQ [$];
  int passCount  = 0;
  int checkCount = 0;

  spike_ram_reader_if #(.DATA_W(DATA_W)) mStream ();

  spike_ram_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_base_addr (baseAddr),
    .i_length    (length),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_ram_addr  (ramAddr),
    .i_ram_dout  (ramDout),
    .m_stream    (mStream)
  );

  always #5 clk = ~clk;

  // Behavioural port B of the spike BRAM: registered read, one edge of latency.
  always @(posedge clk) ramDout <= mem[ramAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge; returns at the first negedge after the command is sampled.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    @(negedge clk);
    start    = 1'b1;
    baseAddr = base;
    length   = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collectBeats(input string tag, input bit toggleReady, input bit checkCnt);
    int got;
    int cyc;
    bit stalled;
    logic [DATA_W-1:0] heldData;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    heldData = '0;
    mStream.ready = 1'b1;
    while (got < expQ.size() && cyc < 60) begin
      if (cyc < addrQ.size()) checkOutput({tag, "_addr"}, 32'(ramAddr), 32'(addrQ[cyc]));
      if (checkCnt) checkOutput({tag, "_fifoOver"}, 32'(dut.u_fifo.o_cnt == 2'd3), 32'd0);
      if (mStream.valid) begin
        if (stalled) checkOutput({tag, "_hold"}, 32'(mStream.data), 32'(heldData));
        if (mStream.ready) begin
          checkOutput({tag, "_data"}, 32'(mStream.data), 32'(expQ[got]));
          checkOutput({tag, "_last"}, 32'(mStream.last), 32'(got == expQ.size() - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          heldData = mStream.data;
        end
      end
      @(negedge clk);
      cyc++;
      if (toggleReady) mStream.ready = ~mStream.ready;
    end
    checkOutput({tag, "_beats"}, 32'(got), 32'(expQ.size()));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_validAfter"}, 32'(mStream.valid), 32'd0);
    checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    mStream.ready = 1'b1;
    addrQ.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    baseAddr = '0;
    length = '0;
    mStream.ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(mStream.valid), 32'd0);
    checkOutput("rst_last", 32'(mStream.last), 32'd0);
    checkOutput("rst_data", 32'(mStream.data), 32'd0);
    checkOutput("rst_addr", 32'(ramAddr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] test 1: base=5 len=4");
    expQ = {8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(10'd5, 11'd4);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    collectBeats("t1", 1'b0, 1'b0);

    $display("[TB] test 2: wrap from 1022");
    expQ  = {8'hFE, 8'hFF, 8'h00, 8'h01};
    addrQ = {10'd1022, 10'd1023, 10'd0, 10'd1};
    applyStimulus(10'd1022, 11'd4);
    collectBeats("t2", 1'b0, 1'b0);

    $display("[TB] test 3: toggling ready");
    expQ = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    applyStimulus(10'd0, 11'd8);
    collectBeats("t3", 1'b1, 1'b1);

    $display("[TB] test 4: zero length, abort in idle, start while busy");
    applyStimulus(10'd3, 11'd0);
    checkOutput("t4_zeroDone", 32'(done), 32'd1);
    checkOutput("t4_zeroBusy", 32'(busy), 32'd0);
    checkOutput("t4_zeroValid", 32'(mStream.valid), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t4_zeroDoneOnce", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("t4_idleAbort", 32'(done), 32'd0);
    expQ = {8'h10, 8'h11, 8'h12};
    applyStimulus(10'd16, 11'd3);
    start    = 1'b1;
    baseAddr = 10'd100;
    length   = 11'd7;
    @(negedge clk);
    start = 1'b0;
    collectBeats("t4", 1'b0, 1'b0);
    checkOutput("t4_noRestart", 32'(busy), 32'd0);

    $display("[TB] test 5: abort with two words buffered");
    mStream.ready = 1'b0;
    applyStimulus(10'd0, 11'd10);
    repeat (3) @(negedge clk);
    checkOutput("t5_validBefore", 32'(mStream.valid), 32'd1);
    checkOutput("t5_dataBefore", 32'(mStream.data), 32'h00);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t5_valid", 32'(mStream.valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("t5_doneOnce", 32'(done), 32'd0);
    expQ = {8'h00};
    applyStimulus(10'd0, 11'd1);
    collectBeats("t5_single", 1'b0, 1'b0);

    $display("[TB] test 6: async reset mid-stream");
    mStream.ready = 1'b0;
    applyStimulus(10'd5, 11'd4);
    repeat (3) @(negedge clk);
    checkOutput("t6_validBefore", 32'(mStream.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_valid", 32'(mStream.valid), 32'd0);
    checkOutput("t6_data", 32'(mStream.data), 32'd0);
    checkOutput("t6_addr", 32'(ramAddr), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_noDone", 32'(done), 32'd0);
    expQ = {8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(10'd5, 11'd4);
    collectBeats("t6_rerun", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
